// File: rtl/interp_upsampler_pkg.sv
// -----------------------------------------------------------------------------
// interp_upsampler_pkg
//   Shared definitions for the linear-interpolating upsampler:
//     FRAC        - fractional bits carried by the interpolation accumulator
//     state_t     - IDLE / RUN control state encoding
//     ratio_log2  - maps the 3-bit ratio code to log2(R), saturating at 4
// -----------------------------------------------------------------------------
package interp_upsampler_pkg;

  localparam int FRAC = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Codes 0..3 select R = 1,2,4,8; every code from 4 upward selects R = 16.
  function automatic logic [2:0] ratio_log2(input logic [2:0] sel);
    return (sel > 3'd4) ? 3'd4 : sel;
  endfunction

endpackage : interp_upsampler_pkg

// File: rtl/interp_upsampler.sv
// -----------------------------------------------------------------------------
// interp_upsampler
//   Accepts one unsigned sample per input handshake and emits R = 2^k linearly
//   interpolated samples stepping from the previous input towards the current
//   one: out_i = prev + floor((cur - prev) * i / R), i = 0..R-1.
//
// Ports
//   clk         in   rising-edge clock
//   sclr_n      in   synchronous active-low reset
//   interp_sel  in   ratio code (0->1, 1->2, 2->4, 3->8, 4..7->16), sampled on accept
//   in_data     in   input sample (unsigned, BIT_WIDTH)
//   in_valid    in   input sample present
//   in_ready    out  block can take an input (combinational from out_ready)
//   out_data    out  interpolated sample
//   out_valid   out  out_data is valid
//   out_ready   in   downstream accepts the current output
// -----------------------------------------------------------------------------
module interp_upsampler
  import interp_upsampler_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 sclr_n,
  input  logic [2:0]           interp_sel,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Accumulator: BIT_WIDTH integer bits, FRAC fraction bits, one sign bit.
  localparam int ACC_W = BIT_WIDTH + 5;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [BIT_WIDTH-1:0]      r_prev;
  logic [BIT_WIDTH-1:0]      r_cur;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   r_step;
  logic [3:0]                r_phase;
  logic [2:0]                r_k;

  logic                      w_accept;
  logic                      w_out_fire;
  logic                      w_last;
  logic [4:0]                w_ratio;
  logic [3:0]                w_phase_max;
  logic [2:0]                w_k_new;
  logic [2:0]                w_shift;
  logic [BIT_WIDTH-1:0]      w_new_prev;
  logic signed [BIT_WIDTH:0] w_diff;
  logic signed [ACC_W-1:0]   w_diff_ext;
  logic signed [ACC_W-1:0]   w_step_new;
  logic signed [ACC_W-1:0]   w_acc_new;

  // ---------------------------------------------------------------------------
  // Burst bookkeeping
  // ---------------------------------------------------------------------------
  // R-1 as a 4-bit value; for k=4 the 5-bit ratio 16 wraps cleanly to 15.
  assign w_ratio     = 5'd1 << r_k;
  assign w_phase_max = 4'(w_ratio - 5'd1);
  assign w_last      = (r_phase == w_phase_max);

  assign w_accept    = in_valid && in_ready;
  assign w_out_fire  = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Reload arithmetic
  // ---------------------------------------------------------------------------
  // A back-to-back reload happens from RUN on the last phase; the sample that
  // was "current" becomes the new starting point in the same edge.
  assign w_new_prev = (r_state == RUN) ? r_cur : r_prev;
  assign w_k_new    = ratio_log2(interp_sel);
  assign w_shift    = 3'(FRAC) - w_k_new;

  // Difference is one bit wider than a sample so it can go negative; scaling by
  // 2^(FRAC-k) is exact because R never exceeds 2^FRAC.
  assign w_diff     = $signed({1'b0, in_data}) - $signed({1'b0, w_new_prev});
  assign w_diff_ext = {{(ACC_W - BIT_WIDTH - 1){w_diff[BIT_WIDTH]}}, w_diff};
  assign w_step_new = w_diff_ext <<< w_shift;
  assign w_acc_new  = {1'b0, w_new_prev, {FRAC{1'b0}}};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge value of every other register, independent of process order.
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = RUN;
    end else if ((r_state == RUN) && w_out_fire && w_last) begin
      w_state_nxt = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    in_ready  = 1'b0;
    if (r_state == RUN) begin
      out_valid = 1'b1;
      // Floor truncation of the fixed-point accumulator.
      out_data  = r_acc[BIT_WIDTH+FRAC-1:FRAC];
    end
    // Ready is held low throughout reset; in RUN it opens only on the final
    // phase when that output is being taken, giving a bubble-free reload.
    if (sclr_n) begin
      in_ready = (r_state == IDLE) || (w_last && out_ready);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      r_prev  <= '0;
      r_cur   <= '0;
      r_acc   <= '0;
      r_step  <= '0;
      r_phase <= '0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_prev  <= w_new_prev;
      r_cur   <= in_data;
      r_k     <= w_k_new;
      r_acc   <= w_acc_new;
      r_step  <= w_step_new;
      r_phase <= '0;
    end else if (w_out_fire) begin
      if (!w_last) begin
        r_acc   <= r_acc + r_step;
        r_phase <= r_phase + 4'd1;
      end else begin
        // Burst complete: the next input interpolates from this sample.
        r_prev  <= r_cur;
      end
    end
  end

endmodule : interp_upsampler
